instruction_fetch_controller: RTL and testbench
===============================================

INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; the ports are `clk` (in, 1, rising-edge clock) and `rst_n` (in, 1, asynchronous active-low reset).
REQ-002 The block SHALL have these program-memory ports:
- `pm_en`: out, 1, read strobe.
- `pm_addr`: out, 14, word address.
- `pm_data`: in, 16, read word, valid one cycle after `pm_en`.
REQ-003 The block SHALL have these decoder ports:
- `dec_instruction`: out, 16, word to the decoder.
- `dec_part2`: out, 1, marks a second-word fetch.
- `dec_id`: in, 8, decoded ID.
- `dec_arg1`: in, 8, first argument.
- `dec_arg2`: in, 8, second argument.
REQ-004 The block SHALL have these execute-handshake ports:
- `ex_valid`: out, 1, instruction offered.
- `ex_ready`: in, 1, execute accepts.
- `ex_id`: out, 8, instruction ID.
- `ex_arg1`: out, 8, first argument.
- `ex_arg2`: out, 8, second argument.
- `ex_k`: out, 16, second word of a two-word instruction.
- `ex_pc_next`: out, 14, address following the instruction.
REQ-005 The block SHALL have these redirect ports:
- `redirect_valid`: in, 1, load a new PC.
- `redirect_pc`: in, 14, branch target.
REQ-006 The block SHALL have a `step` port: in, 1, single-step pulse (see REQ-019).

Function
REQ-007 The FSM SHALL have these states: RST, FETCH1, DEC1, FETCH2, DEC2, ISSUE, and HALT (HALT exists only with the macro in REQ-019).
REQ-008 RST SHALL go to FETCH1 unconditionally on the first clock edge after `rst_n` deasserts.
REQ-009 In FETCH1 the block SHALL drive `pm_en`=1 and `pm_addr`=pc, then go to DEC1.
REQ-010 In DEC1 the block SHALL:
- drive `dec_instruction`=`pm_data` and `dec_part2`=0;
- register `dec_id`, `dec_arg1` and `dec_arg2` into `ex_id`, `ex_arg1` and `ex_arg2`;
- set pc to pc+1.
REQ-011 Two-word instructions are CALL 0x09, JMP 0x13, LDS 0x21 and STS 0x3F; in DEC1 the next state SHALL be FETCH2 for these IDs and ISSUE for all others.
REQ-012 In FETCH2 the block SHALL drive `pm_en`=1 and `pm_addr`=pc, then go to DEC2.
REQ-013 In DEC2 the block SHALL:
- drive `dec_instruction`=`pm_data` and `dec_part2`=1;
- register `ex_k`={`dec_arg2`,`dec_arg1`};
- set pc to pc+1 and go to ISSUE.
REQ-014 For single-word instructions `ex_k` SHALL be 0x0000.
REQ-015 In ISSUE the block SHALL assert `ex_valid`=1 with `ex_pc_next`=pc.
- All `ex_*` outputs SHALL stay stable until `ex_valid`&&`ex_ready`.
- On that handshake the next state SHALL be FETCH1 (or HALT, see REQ-019).
REQ-016 If `redirect_valid`=1 on the handshake cycle, pc SHALL load `redirect_pc`; `redirect_valid` in any other cycle SHALL be ignored.
REQ-017 Outside FETCH1 and FETCH2, `pm_en` SHALL be 0; outside DEC1 and DEC2, `dec_instruction` and `dec_part2` SHALL be 0.
REQ-018 The pc SHALL wrap modulo 2^14, so 0x3FFF+1=0x0000, including in the middle of a two-word instruction.
- Throughput is 3 cycles per single-word instruction and 5 per two-word instruction, with `ex_ready` held high.
- ID 0x00 (NOP or unrecognised) SHALL be issued like any other instruction.

Configuration
REQ-019 With macro `FETCH_SINGLE_STEP_EN` defined:
- after each handshake the FSM SHALL go to HALT;
- HALT SHALL go to FETCH1 in the cycle after `step`=1 is sampled;
- a `step` pulse seen in any other state SHALL be ignored.
REQ-020 Without `FETCH_SINGLE_STEP_EN`, HALT SHALL be absent and `step` SHALL be ignored.

Reset
REQ-021 When `rst_n`=0 the block SHALL immediately set state=RST and pc=0x0000, with all outputs 0: `pm_en`, `pm_addr`, `dec_*`, `ex_valid`, `ex_id`, `ex_arg*`, `ex_k` and `ex_pc_next`.
REQ-022 A reset in any state, including mid two-word fetch or while `ex_valid` is pending, SHALL discard the in-flight instruction; fetch SHALL restart at address 0.

Verification
REQ-023 Single-word instruction, with memory[0]=0x0C12 (ADD) and `ex_ready`=1:
- `ex_valid` SHALL pulse on cycle 3 after reset release;
- `ex_id`=0x02, `ex_arg1`=0x01, `ex_arg2`=0x02, `ex_pc_next`=0x0001.
REQ-024 Two-word instruction, with memory[0]=0x940E and memory[1]=0x1234 (CALL):
- `dec_part2`=1 SHALL be seen in DEC2;
- then `ex_id`=0x09, `ex_k`=0x1234, `ex_pc_next`=0x0002.
REQ-025 Backpressure: with `ex_ready` held at 0 for 4 cycles in ISSUE, `ex_*` SHALL stay stable and `pm_en` SHALL stay 0; the next fetch SHALL occur one cycle after `ex_ready` rises.
REQ-026 Redirect: with `redirect_valid`=1 and `redirect_pc`=0x0100 on a handshake, the next `pm_addr` SHALL be 0x0100; the same redirect applied during DEC1 SHALL be ignored.
REQ-027 Wrap: with pc at 0x3FFF and a JMP fetched there, the second word SHALL be read from 0x0000 and `ex_pc_next` SHALL be 0x0001.
REQ-028 Reset mid-operation: asserting `rst_n`=0 in FETCH2 SHALL give `ex_valid`=0, and after release the first `pm_addr` SHALL be 0x0000. With `FETCH_SINGLE_STEP_EN`, no second fetch SHALL occur until `step` pulses.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_controller
// Purpose  : Fetches one- and two-word instructions from program memory,
//            passes each word through an external decoder and offers the
//            decoded instruction to the execute stage over a valid/ready
//            handshake. A redirect presented on the handshake reloads the PC.
// Options  : FETCH_SINGLE_STEP_EN - when defined, the controller parks in a
//            HALT state after every issued instruction until `step` pulses.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_controller (
    input  logic        clk,
    input  logic        rst_n,
    // program memory
    output logic        pm_en,
    output logic [13:0] pm_addr,
    input  logic [15:0] pm_data,
    // decoder
    output logic [15:0] dec_instruction,
    output logic        dec_part2,
    input  logic [7:0]  dec_id,
    input  logic [7:0]  dec_arg1,
    input  logic [7:0]  dec_arg2,
    // execute handshake
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [7:0]  ex_id,
    output logic [7:0]  ex_arg1,
    output logic [7:0]  ex_arg2,
    output logic [15:0] ex_k,
    output logic [13:0] ex_pc_next,
    // redirect
    input  logic        redirect_valid,
    input  logic [13:0] redirect_pc,
    // single step
    input  logic        step
);

    // IDs of instructions that carry a second program word
    localparam logic [7:0] c_ID_CALL = 8'h09;
    localparam logic [7:0] c_ID_JMP  = 8'h13;
    localparam logic [7:0] c_ID_LDS  = 8'h21;
    localparam logic [7:0] c_ID_STS  = 8'h3F;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH1 = 3'd1,
        S_DEC1   = 3'd2,
        S_FETCH2 = 3'd3,
        S_DEC2   = 3'd4,
        S_ISSUE  = 3'd5
`ifdef FETCH_SINGLE_STEP_EN
        ,
        S_HALT   = 3'd6
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] pc_q, pc_d;
    logic [7:0]  ex_id_q, ex_id_d;
    logic [7:0]  ex_arg1_q, ex_arg1_d;
    logic [7:0]  ex_arg2_q, ex_arg2_d;
    logic [15:0] ex_k_q, ex_k_d;

    logic        two_word;
    logic        handshake;

`ifndef FETCH_SINGLE_STEP_EN
    // Without single-step support the step input has no effect.
    logic        w_unused_step;
    assign w_unused_step = step;
`endif

    // Second-word detection uses the decoder result of the first word.
    assign two_word = (dec_id == c_ID_CALL) || (dec_id == c_ID_JMP) ||
                      (dec_id == c_ID_LDS)  || (dec_id == c_ID_STS);

    assign handshake = (state_q == S_ISSUE) && ex_ready;

    // Registered ID/arguments/K hold the offered instruction steady.
    assign ex_id   = ex_id_q;
    assign ex_arg1 = ex_arg1_q;
    assign ex_arg2 = ex_arg2_q;
    assign ex_k    = ex_k_q;

    // State, PC and captured decoder results; reset discards any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            pc_q      <= 14'h0000;
            ex_id_q   <= 8'h00;
            ex_arg1_q <= 8'h00;
            ex_arg2_q <= 8'h00;
            ex_k_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ex_id_q   <= ex_id_d;
            ex_arg1_q <= ex_arg1_d;
            ex_arg2_q <= ex_arg2_d;
            ex_k_q    <= ex_k_d;
        end
    end

    // Next-state, PC update and per-state output decode.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ex_id_d         = ex_id_q;
        ex_arg1_d       = ex_arg1_q;
        ex_arg2_d       = ex_arg2_q;
        ex_k_d          = ex_k_q;
        pm_en           = 1'b0;
        pm_addr         = 14'h0000;
        dec_instruction = 16'h0000;
        dec_part2       = 1'b0;
        ex_valid        = 1'b0;
        ex_pc_next      = 14'h0000;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                pm_en   = 1'b1;
                pm_addr = pc_q;
                state_d = S_DEC1;
            end
            S_DEC1: begin
                dec_instruction = pm_data;
                ex_id_d         = dec_id;
                ex_arg1_d       = dec_arg1;
                ex_arg2_d       = dec_arg2;
                // single-word instructions carry no K operand
                ex_k_d          = 16'h0000;
                pc_d            = pc_q + 14'd1;
                state_d         = two_word ? S_FETCH2 : S_ISSUE;
            end
            S_FETCH2: begin
                pm_en   = 1'b1;
                pm_addr = pc_q;
                state_d = S_DEC2;
            end
            S_DEC2: begin
                dec_instruction = pm_data;
                dec_part2       = 1'b1;
                ex_k_d          = {dec_arg2, dec_arg1};
                pc_d            = pc_q + 14'd1;
                state_d         = S_ISSUE;
            end
            S_ISSUE: begin
                ex_valid   = 1'b1;
                ex_pc_next = pc_q;
                if (handshake) begin
                    // a redirect only counts when it coincides with the handshake
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end
`ifdef FETCH_SINGLE_STEP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH1;
`endif
                end
            end
`ifdef FETCH_SINGLE_STEP_EN
            S_HALT: begin
                if (step) begin
                    state_d = S_FETCH1;
                end
            end
`endif
            default: begin
                state_d = S_RST;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_controller
// Purpose  : Randomized scoreboard bench. A program-level model walks the
//            memory image and queues the expected fetch addresses and issued
//            instructions; monitors compare whatever the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pm_en;
    logic [13:0] pm_addr;
    logic [15:0] pm_data;
    logic [15:0] dec_instruction;
    logic        dec_part2;
    logic [7:0]  dec_id, dec_arg1, dec_arg2;
    logic        ex_valid, ex_ready;
    logic [7:0]  ex_id, ex_arg1, ex_arg2;
    logic [15:0] ex_k;
    logic [13:0] ex_pc_next;
    logic        redirect_valid;
    logic [13:0] redirect_pc;
    logic        step;

    instruction_fetch_controller dut (
        .clk(clk), .rst_n(rst_n),
        .pm_en(pm_en), .pm_addr(pm_addr), .pm_data(pm_data),
        .dec_instruction(dec_instruction), .dec_part2(dec_part2),
        .dec_id(dec_id), .dec_arg1(dec_arg1), .dec_arg2(dec_arg2),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_id(ex_id), .ex_arg1(ex_arg1), .ex_arg2(ex_arg2),
        .ex_k(ex_k), .ex_pc_next(ex_pc_next),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .step(step)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Environment: program memory (1-cycle read) and a small AVR-like decoder
    // ------------------------------------------------------------------
    logic [15:0] mem [0:16383];
    always @(posedge clk) if (pm_en) pm_data <= mem[pm_addr];

    function automatic logic [23:0] decode(input logic [15:0] w, input logic p2);
        if (p2) return {8'h00, w[7:0], w[15:8]};
        if (w == 16'h940E) return {8'h09, 16'h0000};
        if (w == 16'h940C) return {8'h13, 16'h0000};
        if ((w & 16'hFE0F) == 16'h9000) return {8'h21, 3'b000, w[8:4], 8'h00};
        if ((w & 16'hFE0F) == 16'h9200) return {8'h3F, 3'b000, w[8:4], 8'h00};
        if ((w & 16'hFC00) == 16'h0C00) return {8'h02, 3'b000, w[8:4], 3'b000, w[9], w[3:0]};
        return {8'h00, w[7:0], w[15:8]};
    endfunction

    logic [23:0] dres;
    assign dres = decode(dec_instruction, dec_part2);
    assign {dec_id, dec_arg1, dec_arg2} = dres;

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [7:0]  id;
        logic [7:0]  a1;
        logic [7:0]  a2;
        logic [15:0] k;
        logic [13:0] pcn;
        logic        two;
    } exp_t;
    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] word;
        logic        second;
    } fetch_t;

    exp_t   exp_q[$];
    fetch_t fq[$];
    logic [13:0] m_pc;
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_two(input logic [7:0] id);
        return (id == 8'h09) || (id == 8'h13) || (id == 8'h21) || (id == 8'h3F);
    endfunction

    // Next instruction in program order from the model PC.
    task automatic model_push();
        exp_t        e;
        logic [15:0] w1, w2;
        logic [23:0] d;
        fetch_t      f;
        w1 = mem[m_pc];
        d  = decode(w1, 1'b0);
        e.id = d[23:16]; e.a1 = d[15:8]; e.a2 = d[7:0];
        e.two = is_two(e.id);
        f.addr = m_pc; f.word = w1; f.second = 1'b0;
        fq.push_back(f);
        m_pc = m_pc + 14'd1;
        if (e.two) begin
            w2 = mem[m_pc];
            f.addr = m_pc; f.word = w2; f.second = 1'b1;
            fq.push_back(f);
            e.k  = w2;
            m_pc = m_pc + 14'd1;
        end else begin
            e.k = 16'h0000;
        end
        e.pcn = m_pc;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge
    // ------------------------------------------------------------------
    bit          chk_en = 1'b0;
    int          cyc = 0, base = 0, idle = 0, halt_from = 0;
    bit          pend = 1'b1, prev_fetch = 1'b0, prev_second = 1'b0;
    bit          prev_stall = 1'b0, prev_valid = 1'b0, halted = 1'b0;
    bit          last_fetch_second = 1'b0;
    logic [15:0] prev_word;
    logic [53:0] held;

    always @(negedge clk) begin
        exp_t   e;
        fetch_t f;
        cyc = cyc + 1;
        if (!rst_n || !chk_en) begin
            pend = 1'b1; prev_fetch = 1'b0; prev_stall = 1'b0;
            prev_valid = 1'b0; halted = 1'b0; idle = 0;
        end else begin
            if (pend) begin base = cyc; pend = 1'b0; end
            // decoder side: word presented only in the cycle after a fetch
            if (prev_fetch) begin
                check("dec_instruction", dec_instruction, prev_word);
                check("dec_part2", dec_part2, prev_second);
            end else begin
                check("dec_idle", {dec_part2, dec_instruction}, 17'h0);
            end
            prev_fetch = 1'b0;
            if (pm_en) begin
`ifdef FETCH_SINGLE_STEP_EN
                check("halt_no_fetch", halted, 1'b0);
`endif
                if (fq.size() == 0) begin
                    check("fetch_unexpected", pm_addr, 14'h0);
                    check("fetch_unexpected_flag", 1'b1, 1'b0);
                end else begin
                    f = fq.pop_front();
                    check("pm_addr", pm_addr, f.addr);
                    prev_fetch = 1'b1; prev_word = f.word; prev_second = f.second;
                    last_fetch_second = f.second;
                end
            end
`ifdef FETCH_SINGLE_STEP_EN
            if (halted && cyc >= halt_from && step) begin
                halted = 1'b0;
                base   = cyc;
            end
`endif
            // execute side
            if (ex_valid) begin
                check("pm_en_in_issue", pm_en, 1'b0);
                if (prev_stall)
                    check("ex_stable", {ex_id, ex_arg1, ex_arg2, ex_k, ex_pc_next}, held);
                if (!prev_valid) begin
                    if (exp_q.size() == 0) check("issue_unexpected", 1'b1, 1'b0);
                    else check("issue_latency", cyc - base, exp_q[0].two ? 5 : 3);
                end
                if (ex_ready) begin
                    if (exp_q.size() == 0) begin
                        check("handshake_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ex_id", ex_id, e.id);
                        check("ex_arg1", ex_arg1, e.a1);
                        check("ex_arg2", ex_arg2, e.a2);
                        check("ex_k", ex_k, e.k);
                        check("ex_pc_next", ex_pc_next, e.pcn);
                    end
                    if (redirect_valid) m_pc = redirect_pc;
                    model_push();
                    base = cyc;
`ifdef FETCH_SINGLE_STEP_EN
                    halted = 1'b1;
                    halt_from = cyc + 1;
`endif
                    prev_stall = 1'b0;
                    idle = 0;
                end else begin
                    prev_stall = 1'b1;
                    held = {ex_id, ex_arg1, ex_arg2, ex_k, ex_pc_next};
                end
            end else begin
                prev_stall = 1'b0;
            end
            prev_valid = ex_valid;
            idle++;
            if (idle > 150) begin
                check("handshake_timeout", 1'b1, 1'b0);
                idle = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic check_reset_outputs();
        check("rst_pm_en", pm_en, 1'b0);
        check("rst_pm_addr", pm_addr, 14'h0);
        check("rst_dec", {dec_part2, dec_instruction}, 17'h0);
        check("rst_ex_valid", ex_valid, 1'b0);
        check("rst_ex_args", {ex_id, ex_arg1, ex_arg2}, 24'h0);
        check("rst_ex_k", ex_k, 16'h0);
        check("rst_ex_pc_next", ex_pc_next, 14'h0);
    endtask

    task automatic release_reset();
        exp_q.delete();
        fq.delete();
        m_pc = 14'h0000;
        model_push();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic drive_random();
        int r;
        ex_ready       = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 9) < 2);
        step           = ($urandom_range(0, 9) < 3);
        r = $urandom_range(0, 7);
        case (r)
            0: redirect_pc = 14'h0100;
            1: redirect_pc = 14'h3FFF;
            2: redirect_pc = 14'h3FFE;
            3: redirect_pc = 14'h0000;
            default: redirect_pc = 14'($urandom_range(0, 16383));
        endcase
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive_random();
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; ex_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 14'h0; step = 1'b0;
        for (int i = 0; i < 16384; i++) begin
            case ($urandom_range(0, 9))
                0: mem[i] = 16'h940E;
                1: mem[i] = 16'h940C;
                2: mem[i] = 16'h9000 | 16'($urandom_range(0, 31) << 4);
                3: mem[i] = 16'h9200 | 16'($urandom_range(0, 31) << 4);
                4, 5, 6: mem[i] = 16'h0C00 | 16'($urandom_range(0, 1023));
                default: mem[i] = 16'($urandom_range(0, 65535));
            endcase
        end
        mem[0]       = 16'h0C12;   // ADD r1,r2
        mem[1]       = 16'h940E;   // CALL
        mem[2]       = 16'h1234;   //   K
        mem[14'h3FFF] = 16'h940C;  // JMP whose K wraps to address 0

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        ex_ready = 1'b1;
        step     = 1'b1;
        release_reset();
        run_random(1500);

        // reset while the second word of a two-word instruction is being fetched
        redirect_valid = 1'b0; ex_ready = 1'b1; step = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk); #1;
            if (pm_en && last_fetch_second) found = 1'b1;
        end
        if (!found) begin
            check("fetch2_search_timeout", 1'b1, 1'b0);
        end else begin
            chk_en = 1'b0;
            rst_n  = 1'b0;
            #1;
            check_reset_outputs();
            @(posedge clk); #1;
            check("rst_hold_ex_valid", ex_valid, 1'b0);
        end
        release_reset();
        run_random(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
